// File: rtl/octree_pkg.sv
// Shared types and constants for the octree valid-bit SRAM arbiter.
package octree_pkg;

  typedef enum logic {
    FREE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  localparam int SRAM_RD_LATENCY = 1;

  localparam int REQ_ADD    = 0;
  localparam int REQ_DEL    = 1;
  localparam int REQ_SEARCH = 2;

endpackage

// File: rtl/octree_sram_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  // rotate so that bit 0 corresponds to the pointer position
  assign rot = NUM_REQ'({req, req} >> ptr);

  always_comb begin
    valid = 1'b0;
    off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        off   = IDX_W'(k);
      end
    end
  end

  assign sum = {1'b0, ptr} + {1'b0, off};
  assign idx = (sum >= (IDX_W + 1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W + 1)'(NUM_REQ))
                                             : sum[IDX_W-1:0];

endmodule

// File: rtl/octree_sram_arbiter.sv
// Round-robin arbiter with lock for the shared single-port octree SRAM.
// Optional perf counters are enabled with `define SRAM_ARB_PERF_EN.
//
// state | meaning
// FREE  | no owner; SRAM idle; picking next owner from rr_ptr_q
// OWNED | owner_q drives SRAM pins; released when its req and lock both drop
module octree_sram_arbiter
  import octree_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_BUS_WIDTH = 64,
  parameter int DATA_BUS_WIDTH = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0]                  lock,
  input  logic [NUM_REQ-1:0]                  req_cen,
  input  logic [NUM_REQ-1:0]                  req_gwen,
  input  logic [NUM_REQ*ADDR_BUS_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_BUS_WIDTH-1:0]   req_d,
  output logic [NUM_REQ-1:0]                  gnt,
  output logic [NUM_REQ-1:0]                  rvalid,
  output logic [DATA_BUS_WIDTH-1:0]           rdata,
  output logic                                mem_sram_CEN,
  output logic [ADDR_BUS_WIDTH-1:0]           mem_sram_A,
  output logic [DATA_BUS_WIDTH-1:0]           mem_sram_D,
  output logic                                mem_sram_GWEN,
  input  logic [DATA_BUS_WIDTH-1:0]           mem_sram_Q
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0]                         busy_cycles,
  output logic [31:0]                         conflict_cycles,
  output logic [NUM_REQ*16-1:0]               grant_count
`endif
);
  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e                state_q;
  logic [IDX_W-1:0]          owner_q;
  logic [IDX_W-1:0]          rr_ptr_q;
  logic [NUM_REQ-1:0]        rd_pend_q;

  logic                      pick_valid;
  logic [IDX_W-1:0]          pick_idx;
  logic                      owner_ok;
  logic                      own_req;
  logic                      own_lock;
  logic                      own_cen;
  logic                      own_gwen;
  logic [ADDR_BUS_WIDTH-1:0] own_a;
  logic [DATA_BUS_WIDTH-1:0] own_d;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // owner_ok stays low for an out-of-range owner_q, which keeps the SRAM idle
  always_comb begin
    gnt      = '0;
    owner_ok = 1'b0;
    own_req  = 1'b0;
    own_lock = 1'b0;
    own_cen  = 1'b1;
    own_gwen = 1'b1;
    own_a    = '0;
    own_d    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state_q == OWNED && owner_q == IDX_W'(i)) begin
        gnt[i]   = 1'b1;
        owner_ok = 1'b1;
        own_req  = req[i];
        own_lock = lock[i];
        own_cen  = req_cen[i];
        own_gwen = req_gwen[i];
        own_a    = req_a[i*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH];
        own_d    = req_d[i*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
      end
    end
  end

  assign mem_sram_CEN  = own_cen;
  assign mem_sram_GWEN = own_gwen;
  assign mem_sram_A    = own_a;
  assign mem_sram_D    = own_d;
  assign rvalid        = rd_pend_q;
  assign rdata         = mem_sram_Q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FREE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      rd_pend_q <= '0;
    end else begin
      rd_pend_q <= gnt & ~req_cen & req_gwen;
      case (state_q)
        FREE: begin
          if (pick_valid) begin
            state_q  <= OWNED;
            owner_q  <= pick_idx;
            rr_ptr_q <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
          end
        end
        OWNED: begin
          if (!owner_ok || (!own_req && !own_lock)) state_q <= FREE;
        end
        default: state_q <= FREE;
      endcase
    end
  end

`ifdef SRAM_ARB_PERF_EN
  logic        conflict;
  logic [15:0] gcnt_q [NUM_REQ];

  assign conflict = (state_q == OWNED) ? |(req & ~gnt)
                                       : ((req & (req - NUM_REQ'(1))) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cycles     <= '0;
      conflict_cycles <= '0;
      for (int i = 0; i < NUM_REQ; i++) gcnt_q[i] <= '0;
    end else begin
      if (!mem_sram_CEN && busy_cycles != '1) busy_cycles <= busy_cycles + 32'd1;
      if (conflict && conflict_cycles != '1) conflict_cycles <= conflict_cycles + 32'd1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (state_q == FREE && pick_valid && pick_idx == IDX_W'(i) && gcnt_q[i] != '1)
          gcnt_q[i] <= gcnt_q[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_gcnt
    assign grant_count[g*16 +: 16] = gcnt_q[g];
  end
`endif

endmodule

// File: tb/tb_octree_sram_arbiter.sv
// Scoreboard bench for octree_sram_arbiter: reference model, SRAM model, directed and random phases.
module tb_octree_sram_arbiter;
  localparam int N  = 3;
  localparam int AW = 64;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req, lock, req_cen, req_gwen;
  logic [N*AW-1:0]   req_a;
  logic [N*DW-1:0]   req_d;
  wire  [N-1:0]      gnt, rvalid;
  wire  [DW-1:0]     rdata;
  wire               mem_sram_CEN, mem_sram_GWEN;
  wire  [AW-1:0]     mem_sram_A;
  wire  [DW-1:0]     mem_sram_D;
  logic [DW-1:0]     mem_sram_Q = '0;
`ifdef SRAM_ARB_PERF_EN
  wire  [31:0]       busy_cycles, conflict_cycles;
  wire  [N*16-1:0]   grant_count;
`endif

  octree_sram_arbiter #(.NUM_REQ(N), .ADDR_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .req_cen(req_cen),
    .req_gwen(req_gwen), .req_a(req_a), .req_d(req_d), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .mem_sram_CEN(mem_sram_CEN), .mem_sram_A(mem_sram_A),
    .mem_sram_D(mem_sram_D), .mem_sram_GWEN(mem_sram_GWEN), .mem_sram_Q(mem_sram_Q)
`ifdef SRAM_ARB_PERF_EN
    , .busy_cycles(busy_cycles), .conflict_cycles(conflict_cycles), .grant_count(grant_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { int idx; logic [DW-1:0] data; } rd_t;
  rd_t          sb[$];
  int           dut_grants[$];
  logic [DW-1:0] sram    [16];
  logic [DW-1:0] mdl_mem [16];
  int           m_owner, m_ptr, m_j, m_a;
  logic [N-1:0] gnt_prev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM macro: one-cycle read latency
  always @(posedge clk) begin
    if (!mem_sram_CEN) begin
      if (!mem_sram_GWEN) sram[mem_sram_A[3:0]] <= mem_sram_D;
      else                mem_sram_Q <= sram[mem_sram_A[3:0]];
    end
  end

  // Reference model: owner (-1 = none) and next-search start position
  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
    end else begin
      if (m_owner >= 0 && !req_cen[m_owner]) begin
        m_a = int'(req_a[m_owner*AW +: 4]);
        if (req_gwen[m_owner]) sb.push_back('{m_owner, mdl_mem[m_a]});
        else                   mdl_mem[m_a] = req_d[m_owner*DW +: DW];
      end
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          m_j = (m_ptr + k) % N;
          if (req[m_j]) begin
            m_owner = m_j;
            m_ptr   = (m_j + 1) % N;
            break;
          end
        end
      end else if (!req[m_owner] && !lock[m_owner]) begin
        m_owner = -1;
      end
    end
  end

  // Pin checker and grant logger
  always @(negedge clk) begin
    if (!rst_n) begin
      gnt_prev = '0;
    end else begin
      check("gnt", 64'(gnt), (m_owner >= 0) ? 64'(1 << m_owner) : 64'd0);
      check("cen", 64'(mem_sram_CEN), (m_owner >= 0) ? 64'(req_cen[m_owner]) : 64'd1);
      if (m_owner >= 0 && !req_cen[m_owner]) begin
        check("addr", mem_sram_A, req_a[m_owner*AW +: AW]);
        check("gwen", 64'(mem_sram_GWEN), 64'(req_gwen[m_owner]));
        if (!req_gwen[m_owner]) check("wdata", mem_sram_D, req_d[m_owner*DW +: DW]);
      end
      if (gnt != '0 && gnt_prev == '0) begin
        for (int i = 0; i < N; i++) if (gnt[i]) dut_grants.push_back(i);
      end
      gnt_prev = gnt;
    end
  end

  // Read-return monitor
  always @(negedge clk) begin
    rd_t e;
    if (rst_n) begin
      if (rvalid != '0) begin
        if (sb.size() == 0) check("rvalid_spurious", 64'(rvalid), 64'd0);
        else begin
          e = sb.pop_front();
          check("rvalid", 64'(rvalid), 64'(1 << e.idx));
          check("rdata", rdata, e.data);
        end
      end else if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rvalid_missing", 64'(rvalid), 64'(1 << e.idx));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; lock = '0; req_cen = '1; req_gwen = '1; req_a = '0; req_d = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic wait_gnt(input int i, input string name);
    for (int c = 0; c < 12; c++) begin
      if (gnt[i]) return;
      step();
    end
    checks++; errors++;
    $display("FAIL %s: gnt[%0d] never asserted, gnt=%0b", name, i, gnt);
  endtask

  task automatic set_acc(input int i, input logic cen, input logic gwen, input int addr,
                         input logic [DW-1:0] d);
    req_cen[i]           = cen;
    req_gwen[i]          = gwen;
    req_a[i*AW +: AW]    = AW'(addr);
    req_d[i*DW +: DW]    = d;
  endtask

  int need [N];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      sram[i]    = {$urandom, $urandom};
      mdl_mem[i] = sram[i];
    end
    sram[3] = 64'h0F; mdl_mem[3] = 64'h0F;

    // reset state and idle
    do_reset();
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_cen", 64'(mem_sram_CEN), 64'd1);
    check("rst_gwen", 64'(mem_sram_GWEN), 64'd1);
    check("rst_a", mem_sram_A, 64'd0);
    check("rst_d", mem_sram_D, 64'd0);
    repeat (5) step();

    // single read by master 1, req dropped with the access
    do_reset();
    req = 3'b010;
    step();
    check("s2_gnt", 64'(gnt), 64'b010);
    set_acc(1, 1'b0, 1'b1, 5, '0);
    req = 3'b000;
    step();
    req_cen = '1;
    check("s2_rvalid", 64'(rvalid), 64'b010);
    check("s2_rdata", rdata, mdl_mem[5]);
    check("s2_free", 64'(gnt), 64'd0);
    repeat (2) step();

    // all request, each drops after one access; master 0 goes twice
    do_reset();
    dut_grants.delete();
    need[0] = 2; need[1] = 1; need[2] = 1;
    req = 3'b111;
    step();
    for (int c = 0; c < 30; c++) begin
      if (need[0] + need[1] + need[2] == 0) break;
      req_cen = '1;
      for (int i = 0; i < N; i++) begin
        req[i] = (need[i] > 0);
        if (gnt[i] && need[i] > 0) begin
          set_acc(i, 1'b0, 1'b1, i, '0);
          req[i] = 1'b0;
          need[i]--;
        end
      end
      step();
    end
    idle_inputs();
    repeat (3) step();
    check("rr_count", 64'(dut_grants.size()), 64'd4);
    if (dut_grants.size() == 4) begin
      check("rr_g0", 64'(dut_grants[0]), 64'd0);
      check("rr_g1", 64'(dut_grants[1]), 64'd1);
      check("rr_g2", 64'(dut_grants[2]), 64'd2);
      check("rr_g3", 64'(dut_grants[3]), 64'd0);
    end

    // locked read-modify-write by master 0 while master 2 waits
    do_reset();
    dut_grants.delete();
    req = 3'b101; lock = 3'b001;
    step();
    wait_gnt(0, "lock_gnt0");
    set_acc(0, 1'b0, 1'b1, 3, '0);
    step();
    set_acc(0, 1'b0, 1'b0, 3, 64'h1F);
    req[0] = 1'b0;
    step();
    check("lock_hold", 64'(gnt), 64'b001);
    set_acc(0, 1'b1, 1'b1, 0, '0);
    lock[0] = 1'b0;
    step();
    wait_gnt(2, "lock_gnt2");
    req = '0;
    repeat (3) step();
    check("lock_order_n", 64'(dut_grants.size()), 64'd2);
    if (dut_grants.size() == 2) begin
      check("lock_first", 64'(dut_grants[0]), 64'd0);
      check("lock_second", 64'(dut_grants[1]), 64'd2);
    end
    check("lock_sram3", sram[3], 64'h1F);

    // async reset with a read return pending
    do_reset();
    req = 3'b001; lock = 3'b001;
    step();
    wait_gnt(0, "arst_gnt");
    set_acc(0, 1'b0, 1'b1, 7, '0);
    step();
    check("arst_pre_rvalid", 64'(rvalid), 64'b001);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    check("arst_gnt", 64'(gnt), 64'd0);
    check("arst_cen", 64'(mem_sram_CEN), 64'd1);
    check("arst_rvalid", 64'(rvalid), 64'd0);
    idle_inputs();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) step();

    // randomized traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req      = N'($urandom);
      lock     = N'($urandom & $urandom & $urandom);
      req_cen  = N'($urandom);
      req_gwen = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_a[i*AW +: AW] = AW'($urandom_range(0, 15));
        req_d[i*DW +: DW] = {$urandom, $urandom};
      end
      step();
    end
    idle_inputs();
    repeat (4) step();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
